// File: rtl/dp_rot_pp_buffer_ctrl_pkg.sv
// dp_rot_pp_buffer_ctrl_pkg: bank state encodings and default read latency for the rotating buffer controller.
package dp_rot_pp_buffer_ctrl_pkg;
  localparam int COMMON_BRAM_DELAY = 2;
  // Encodings step by 2 per role: pred = 2r, own = 2r+1, next = (2r+2) mod 6.
  typedef enum logic [2:0] {
    DP_BUF_EMPTY    = 3'd0,
    DP_BUF_AXI      = 3'd1,
    DP_BUF_RDY_NTT  = 3'd2,
    DP_BUF_NTT      = 3'd3,
    DP_BUF_RDY_MADD = 3'd4,
    DP_BUF_MADD     = 3'd5
  } buf_st_e;
endpackage

// File: rtl/dp_buf_role_ptr.sv
// dp_buf_role_ptr: one role's done-edge detect, ownership flag, acquire/release and ring pointer.
module dp_buf_role_ptr
  import dp_rot_pp_buffer_ctrl_pkg::*;
#(
  parameter int      NUM_BUF    = 4,
  parameter buf_st_e PRED_STATE = DP_BUF_EMPTY,
  parameter buf_st_e OWN_STATE  = DP_BUF_AXI,
  parameter buf_st_e NEXT_STATE = DP_BUF_RDY_NTT,
  localparam int     PTR_W      = $clog2(NUM_BUF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_done,
  input  buf_st_e          i_st,
  output logic             o_rdy,
  output logic [PTR_W-1:0] o_ptr,
  output logic             o_st_we,
  output buf_st_e          o_st_nxt,
  output logic             o_err
);
  logic r_done_d, r_rdy;
  logic [PTR_W-1:0] r_ptr;
  logic w_edge, w_acq, w_rel;
  assign w_edge   = i_done & ~r_done_d;
  assign w_acq    = i_en & ~r_rdy & (i_st == PRED_STATE);
  assign w_rel    = w_edge & r_rdy;
  assign o_st_we  = w_acq | w_rel;
  assign o_st_nxt = w_rel ? NEXT_STATE : OWN_STATE;
  assign o_err    = w_edge & ~r_rdy;
  assign o_rdy    = r_rdy;
  assign o_ptr    = r_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_done_d <= 1'b0;
      r_rdy    <= 1'b0;
      r_ptr    <= '0;
    end else begin
      r_done_d <= i_done;
      r_rdy    <= w_acq | (r_rdy & ~w_rel);
      if (w_rel) r_ptr <= (r_ptr == PTR_W'(NUM_BUF - 1)) ? '0 : r_ptr + 1'b1;
    end
endmodule

// File: rtl/dp_rot_pp_buffer_ctrl.sv
// dp_rot_pp_buffer_ctrl: N-deep rotating ping-pong controller steering AXI/NTT/MADD
// traffic onto a ring of external polyvec_ram banks with per-bank state tracking.
module dp_rot_pp_buffer_ctrl
  import dp_rot_pp_buffer_ctrl_pkg::*;
#(
  parameter int  COE_WIDTH     = 39,
  parameter int  ADDR_WIDTH    = 9,
  parameter int  NUM_POLY      = 3,
  parameter int  NUM_BASE_BANK = 8,
  parameter int  NUM_BUF       = 4,
  parameter int  RD_LAT        = COMMON_BRAM_DELAY,
  localparam int BW            = NUM_BASE_BANK * NUM_POLY,
  localparam int PTR_W         = $clog2(NUM_BUF),
  localparam int AW            = ADDR_WIDTH * BW,
  localparam int DW            = COE_WIDTH * BW
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_axi_done,
  input  logic                              i_ntt_done,
  input  logic                              i_madd_done,
  output logic                              o_axi_rdy,
  output logic                              o_ntt_rdy,
  output logic                              o_madd_rdy,
  input  logic [BW-1:0]                     i_axi_we,
  input  logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] i_axi_wraddr,
  input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  i_axi_data,
  input  logic [BW-1:0]                     i_ntt_we,
  input  logic [AW-1:0]                     i_ntt_wraddr,
  input  logic [DW-1:0]                     i_ntt_data,
  input  logic [AW-1:0]                     i_ntt_rdaddr,
  output logic [DW-1:0]                     o_ntt_data,
  input  logic [AW-1:0]                     i_madd_rdaddr,
  output logic [DW-1:0]                     o_madd_data,
  input  logic [ADDR_WIDTH-1:0]             i_tap_rdaddr,
  output logic [DW-1:0]                     o_tap_data,
  output logic                              o_tap_vld,
  output logic [NUM_BUF*BW-1:0]             o_polyvec_wea,
  output logic [NUM_BUF*AW-1:0]             o_polyvec_addra,
  output logic [NUM_BUF*DW-1:0]             o_polyvec_dina,
  output logic [NUM_BUF*AW-1:0]             o_polyvec_addrb,
  input  logic [NUM_BUF*DW-1:0]             i_polyvec_doutb,
  output logic [PTR_W:0]                    o_occupancy,
  output logic                              o_err
);
  buf_st_e          r_st      [NUM_BUF];
  buf_st_e          w_st_nxt  [NUM_BUF];
  buf_st_e          w_role_st [3];
  logic [PTR_W-1:0] w_ptr     [3];
  logic [PTR_W:0]   r_pipe    [RD_LAT][3];
  logic [PTR_W:0]   w_pin     [3];
  logic [2:0]       w_rdy, w_st_we, w_err, w_done;
  logic             r_run, r_err, w_tap;
  assign w_done = {i_madd_done, i_ntt_done, i_axi_done};
  for (genvar r = 0; r < 3; r++) begin : g_role
    dp_buf_role_ptr #(
      .NUM_BUF   (NUM_BUF),
      .PRED_STATE(buf_st_e'(3'(2 * r))),
      .OWN_STATE (buf_st_e'(3'(2 * r + 1))),
      .NEXT_STATE(buf_st_e'(3'((2 * r + 2) % 6)))
    ) u_role (
      .clk     (clk),
      .rst     (rst),
      .i_en    (r_run),
      .i_done  (w_done[r]),
      .i_st    (r_st[w_ptr[r]]),
      .o_rdy   (w_rdy[r]),
      .o_ptr   (w_ptr[r]),
      .o_st_we (w_st_we[r]),
      .o_st_nxt(w_role_st[r]),
      .o_err   (w_err[r])
    );
  end
  always_comb begin
    w_st_nxt = r_st;
    for (int k = 0; k < 3; k++) if (w_st_we[k]) w_st_nxt[w_ptr[k]] = w_role_st[k];
  end
  // r_run holds off the first grant for one cycle after reset release.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int b = 0; b < NUM_BUF; b++) r_st[b] <= DP_BUF_EMPTY;
      for (int k = 0; k < RD_LAT; k++) r_pipe[k] <= '{default: '0};
      r_run <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_pipe[0] <= w_pin;
      for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
      r_run <= 1'b1;
      r_err <= r_err | (|w_err);
    end
  assign w_tap    = (r_st[w_ptr[2]] == DP_BUF_RDY_MADD) & ~w_rdy[2];
  assign w_pin[0] = {w_rdy[1], w_ptr[1]};
  assign w_pin[1] = {w_rdy[2], w_ptr[2]};
  assign w_pin[2] = {w_tap, w_ptr[2]};
  for (genvar b = 0; b < NUM_BUF; b++) begin : g_bank
    logic w_axi, w_ntt, w_madd, w_tap_b;
    assign w_axi   = r_st[b] == DP_BUF_AXI;
    assign w_ntt   = r_st[b] == DP_BUF_NTT;
    assign w_madd  = r_st[b] == DP_BUF_MADD;
    assign w_tap_b = w_tap & (w_ptr[2] == PTR_W'(b));
    assign o_polyvec_wea[b*BW +: BW]   = w_axi ? i_axi_we : w_ntt ? i_ntt_we : '0;
    assign o_polyvec_addra[b*AW +: AW] = w_axi ? {NUM_POLY{i_axi_wraddr}} : w_ntt ? i_ntt_wraddr : '0;
    assign o_polyvec_dina[b*DW +: DW]  = w_axi ? {NUM_POLY{i_axi_data}} : w_ntt ? i_ntt_data : '0;
    assign o_polyvec_addrb[b*AW +: AW] = w_ntt ? i_ntt_rdaddr : w_madd ? i_madd_rdaddr :
                                         w_tap_b ? {BW{i_tap_rdaddr}} : '0;
  end
  assign o_ntt_data  = r_pipe[RD_LAT-1][0][PTR_W] ?
                       i_polyvec_doutb[int'(r_pipe[RD_LAT-1][0][PTR_W-1:0])*DW +: DW] : '0;
  assign o_madd_data = r_pipe[RD_LAT-1][1][PTR_W] ?
                       i_polyvec_doutb[int'(r_pipe[RD_LAT-1][1][PTR_W-1:0])*DW +: DW] : '0;
  assign o_tap_data  = r_pipe[RD_LAT-1][2][PTR_W] ?
                       i_polyvec_doutb[int'(r_pipe[RD_LAT-1][2][PTR_W-1:0])*DW +: DW] : '0;
  assign o_tap_vld   = r_pipe[RD_LAT-1][2][PTR_W];
  always_comb begin
    o_occupancy = '0;
    for (int b = 0; b < NUM_BUF; b++) o_occupancy += (PTR_W + 1)'(r_st[b] != DP_BUF_EMPTY);
  end
  assign o_axi_rdy  = w_rdy[0];
  assign o_ntt_rdy  = w_rdy[1];
  assign o_madd_rdy = w_rdy[2];
  assign o_err      = r_err;
endmodule

// File: tb/tb_dp_rot_pp_buffer_ctrl.sv
// tb_dp_rot_pp_buffer_ctrl: directed bench for the rotating buffer controller with a behavioural bank model.
module tb_dp_rot_pp_buffer_ctrl;
  localparam int COE = 39, AWID = 9, NP = 3, NBB = 8, NB = 4, LAT = 2;
  localparam int BW = NBB * NP, AW = AWID * BW, DW = COE * BW;
  logic clk, rst, axi_done, ntt_done, madd_done, axi_rdy, ntt_rdy, madd_rdy, tap_vld, err;
  logic [BW-1:0] axi_we, ntt_we;
  logic [AWID*NBB-1:0] axi_wraddr;
  logic [COE*NBB-1:0] axi_data;
  logic [AW-1:0] ntt_wraddr, ntt_rdaddr, madd_rdaddr;
  logic [DW-1:0] ntt_wdata, ntt_rdata, madd_data, tap_data;
  logic [AWID-1:0] tap_rdaddr;
  logic [NB*BW-1:0] wea;
  logic [NB*AW-1:0] addra, addrb;
  logic [NB*DW-1:0] dina, doutb;
  logic [2:0] occ;
  logic [COE-1:0] mem [NB][BW][512];
  logic [NB*DW-1:0] rd_pipe [LAT];
  int n_asrt = 0, n_fail = 0;

  dp_rot_pp_buffer_ctrl #(
    .COE_WIDTH(COE), .ADDR_WIDTH(AWID), .NUM_POLY(NP), .NUM_BASE_BANK(NBB), .NUM_BUF(NB), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .i_axi_done(axi_done), .i_ntt_done(ntt_done), .i_madd_done(madd_done),
    .o_axi_rdy(axi_rdy), .o_ntt_rdy(ntt_rdy), .o_madd_rdy(madd_rdy),
    .i_axi_we(axi_we), .i_axi_wraddr(axi_wraddr), .i_axi_data(axi_data),
    .i_ntt_we(ntt_we), .i_ntt_wraddr(ntt_wraddr), .i_ntt_data(ntt_wdata),
    .i_ntt_rdaddr(ntt_rdaddr), .o_ntt_data(ntt_rdata), .i_madd_rdaddr(madd_rdaddr), .o_madd_data(madd_data),
    .i_tap_rdaddr(tap_rdaddr), .o_tap_data(tap_data), .o_tap_vld(tap_vld),
    .o_polyvec_wea(wea), .o_polyvec_addra(addra), .o_polyvec_dina(dina), .o_polyvec_addrb(addrb),
    .i_polyvec_doutb(doutb), .o_occupancy(occ), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < BW; l++) begin
        if (wea[b*BW+l]) mem[b][l][addra[(b*BW+l)*AWID +: AWID]] <= dina[(b*BW+l)*COE +: COE];
        rd_pipe[0][(b*BW+l)*COE +: COE] <= mem[b][l][addrb[(b*BW+l)*AWID +: AWID]];
      end
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign doutb = rd_pipe[LAT-1];

  function automatic logic [DW-1:0] vec(input int p);
    for (int l = 0; l < BW; l++) vec[l*COE +: COE] = {1'b1, 6'(p + 1), 32'(l * 17 + 3)};
  endfunction

  function automatic logic [COE*NBB-1:0] axi_vec(input int p);
    for (int l = 0; l < NBB; l++) axi_vec[l*COE +: COE] = {1'b0, 6'(p + 9), 32'(l * 5 + 100)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] m);
    {madd_done, ntt_done, axi_done} = m;
    tick();
    {madd_done, ntt_done, axi_done} = 3'b000;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (low 240 bits)", tag, obs[239:0], exp[239:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    {axi_done, ntt_done, madd_done} = 3'b000;
    axi_we = '0; ntt_we = '0; axi_wraddr = '0; axi_data = '0;
    ntt_wraddr = '0; ntt_wdata = '0; ntt_rdaddr = '0; madd_rdaddr = '0;
    tap_rdaddr = 9'd7;
    repeat (2) tick();
    chk("rst_axi_rdy", axi_rdy, 1'b0);
    chk("rst_occ", occ, 3'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_wea", wea, '0);
    chk("rst_tap_vld", tap_vld, 1'b0);
    rst = 1'b0;
    tick();
    chk("grant_edge1", axi_rdy, 1'b0);
    tick();
    chk("grant_edge2", axi_rdy, 1'b1);
    chk("grant_ntt_idle", ntt_rdy, 1'b0);
    chk("grant_madd_idle", madd_rdy, 1'b0);
    chk("grant_occ", occ, 3'd1);
    for (int p = 0; p < 3; p++) begin
      axi_we = '1; axi_wraddr = {NBB{9'd5}}; axi_data = axi_vec(p);
      #1 chk("axi_wea", wea[p*BW +: BW], {BW{1'b1}});
      tick();
      axi_we = '0;
      pulse(3'b001);
      chk("axi_rel", axi_rdy, 1'b0);
      tick();
      chk("ntt_acq", ntt_rdy, 1'b1);
      chk("axi_next", axi_rdy, 1'b1);
      chk("occ_pass", occ, 3'd2);
      ntt_we = '1; ntt_wraddr = {BW{9'd7}}; ntt_wdata = vec(p); ntt_rdaddr = {BW{9'd5}};
      tick();
      ntt_we = '0; ntt_rdaddr = {BW{9'd7}};
      tick();
      chk("ntt_rd_axi", ntt_rdata, {NP{axi_vec(p)}});
      tick();
      chk("ntt_rd_lat", ntt_rdata, vec(p));
      pulse(3'b010);
      chk("ntt_rel", ntt_rdy, 1'b0);
      chk("madd_pre", madd_rdy, 1'b0);
      tick();
      chk("madd_acq", madd_rdy, 1'b1);
      chk("tap_vld_early", tap_vld, 1'b0);
      tick();
      chk("tap_vld", tap_vld, 1'b1);
      chk("tap_data", tap_data, vec(p));
      madd_rdaddr = {BW{9'd7}};
      repeat (2) tick();
      chk("madd_data", madd_data, vec(p));
      chk("tap_vld_off", tap_vld, 1'b0);
      axi_we = '1; ntt_we = '1;
      #1 chk("madd_wea0", wea[p*BW +: BW], '0);
      axi_we = '0; ntt_we = '0;
      pulse(3'b100);
      chk("madd_rel", madd_rdy, 1'b0);
      tick();
      chk("occ_after_madd", occ, 3'd1);
    end
    pulse(3'b001); tick();
    pulse(3'b010); tick();
    pulse(3'b001); tick();
    chk("dual_ntt_own", ntt_rdy, 1'b1);
    chk("dual_madd_own", madd_rdy, 1'b1);
    pulse(3'b110);
    chk("dual_ntt_rel", ntt_rdy, 1'b0);
    chk("dual_madd_rel", madd_rdy, 1'b0);
    chk("dual_err", err, 1'b0);
    tick();
    chk("dual_madd_reacq", madd_rdy, 1'b1);
    chk("dual_ntt_idle", ntt_rdy, 1'b0);
    chk("dual_occ", occ, 3'd2);
    pulse(3'b100); tick();
    chk("err_pre_madd", madd_rdy, 1'b0);
    chk("err_pre_occ", occ, 3'd1);
    chk("err_pre", err, 1'b0);
    pulse(3'b100);
    chk("err_set", err, 1'b1);
    chk("err_madd_idle", madd_rdy, 1'b0);
    chk("err_occ", occ, 3'd1);
    repeat (2) tick();
    chk("err_sticky", err, 1'b1);
    chk("err_axi_kept", axi_rdy, 1'b1);
    pulse(3'b001); tick();
    chk("mid_ntt_own", ntt_rdy, 1'b1);
    repeat (2) tick();
    chk("mid_ntt_data", ntt_rdata, vec(1));
    #2 rst = 1'b1;
    ntt_we = '1;
    #1;
    chk("arst_ntt_rdy", ntt_rdy, 1'b0);
    chk("arst_ntt_data", ntt_rdata, '0);
    chk("arst_occ", occ, 3'd0);
    chk("arst_err", err, 1'b0);
    chk("arst_wea", wea, '0);
    chk("arst_axi_rdy", axi_rdy, 1'b0);
    @(negedge clk);
    rst = 1'b0; ntt_we = '0; axi_we = '1;
    tick();
    chk("regrant_edge1", axi_rdy, 1'b0);
    tick();
    chk("regrant_edge2", axi_rdy, 1'b1);
    chk("regrant_wea0", wea[0 +: BW], {BW{1'b1}});
    chk("regrant_occ", occ, 3'd1);
    axi_we = '0;
    repeat (3) begin
      pulse(3'b001); tick();
    end
    chk("ahead_axi_rdy", axi_rdy, 1'b1);
    chk("ahead_occ", occ, 3'd4);
    chk("ahead_ntt_rdy", ntt_rdy, 1'b1);
    axi_we = '1;
    #1 chk("ahead_wea3", wea[3*BW +: BW], {BW{1'b1}});
    chk("ahead_wea0", wea[0 +: BW], '0);
    axi_we = '0;
    pulse(3'b001);
    chk("full_rel", axi_rdy, 1'b0);
    repeat (2) tick();
    chk("full_wait", axi_rdy, 1'b0);
    chk("full_occ", occ, 3'd4);
    chk("full_err", err, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
